hier_c_rr_arbiter: RTL and testbench

- Shares the single downstream cSt channel of the hierIncludeC block among NUM_REQ upstream requesters.
- Arbitration is round-robin with burst hold. A granted requester keeps the channel for up to MAX_BURST beats, then the grant rotates.
- Sits between the requester-side cSt interfaces and the hierIncludeC consumer. All channels use a valid/ready handshake.

---
 rtl/hier_c_rr_arbiter_pkg.sv | 18 +
 rtl/hier_c_rr_arbiter_if.sv | 30 +++
 rtl/hier_c_rr_arbiter_pick.sv | 46 ++++
 rtl/hier_c_rr_arbiter.sv | 104 ++++++++++
 tb/tb_hier_c_rr_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hier_c_rr_arbiter_pkg.sv
// Shared types and constants for the hierIncludeC cSt channel and its arbiter.
package hierIncludeC_package;

    typedef logic [15:0] cSizeT;

    typedef struct packed {
        cSizeT cAnother;
    } cSt;

    typedef enum logic {
        IDLE,
        BURST
    } hierCArbStateT;

    localparam int HIER_C_ARB_NUM_REQ   = 4;
    localparam int HIER_C_ARB_MAX_BURST = 8;

endpackage

// File: rtl/hier_c_rr_arbiter_if.sv
// Requester-side and downstream cSt valid/ready bundle plus grant status of the arbiter.
interface hier_c_rr_arbiter_if
    import hierIncludeC_package::*;
#(
    parameter int NUM_REQ = HIER_C_ARB_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0] req_vld;
    cSt   [NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0] req_rdy;
    logic               out_vld;
    cSt                 out_data;
    logic               out_rdy;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic               burst_done;

    // The arbiter side drives ready, the downstream beat and the grant status.
    modport master (
        input  req_vld, req_data, out_rdy,
        output req_rdy, out_vld, out_data, grant_vld, grant_id, burst_done
    );

    modport slave (
        output req_vld, req_data, out_rdy,
        input  req_rdy, out_vld, out_data, grant_vld, grant_id, burst_done
    );

endinterface

// File: rtl/hier_c_rr_arbiter_pick.sv
// Round-robin picker: first set request at or above rrPtr, wrapping. Purely combinational.
module hier_c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rrPtr,
    output logic               found,
    output logic [ID_W-1:0]    pickId
);

    localparam logic [ID_W:0] NUM = (ID_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [ID_W-1:0]      rotIdx;
    logic [ID_W:0]        unrotated;

    // Rotating by rrPtr puts the highest-priority requester at bit 0.
    always_comb begin
        doubled = {req, req} >> rrPtr;
        rotated = doubled[NUM_REQ-1:0];
    end

    always_comb begin
        found  = 1'b0;
        rotIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                rotIdx = ID_W'(i);
            end
        end
    end

    // Modulo add works for non-power-of-two NUM_REQ since both terms are below NUM_REQ.
    always_comb begin
        unrotated = {1'b0, rotIdx} + {1'b0, rrPtr};
        if (unrotated >= NUM) begin
            pickId = ID_W'(unrotated - NUM);
        end else begin
            pickId = unrotated[ID_W-1:0];
        end
    end

endmodule

// File: rtl/hier_c_rr_arbiter.sv
// Round-robin arbiter with burst hold sharing the hierIncludeC cSt channel among NUM_REQ requesters.
module hier_c_rr_arbiter
    import hierIncludeC_package::*;
#(
    parameter int NUM_REQ   = HIER_C_ARB_NUM_REQ,
    parameter int MAX_BURST = HIER_C_ARB_MAX_BURST,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    hier_c_rr_arbiter_if.master bus
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    hierCArbStateT    state, stateNext;
    logic [ID_W-1:0]  rrPtr, rrPtrNext;
    logic [ID_W-1:0]  grantId, grantIdNext;
    logic [CNT_W-1:0] beatCnt, beatCntNext;
    logic             burstDone, burstDoneNext;

    logic             pickFound;
    logic [ID_W-1:0]  pickId;
    logic             curVld;
    logic             transfer;
    logic             releaseGrant;

    hier_c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) picker (
        .req    (bus.req_vld),
        .rrPtr  (rrPtr),
        .found  (pickFound),
        .pickId (pickId)
    );

    // A grant ends either on its last allowed beat or as soon as the owner stops offering data.
    assign curVld       = bus.req_vld[grantId];
    assign transfer     = (state == BURST) && curVld && bus.out_rdy;
    assign releaseGrant = (state == BURST) && (!curVld || (transfer && (beatCnt == LAST_BEAT)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rrPtr     <= '0;
            grantId   <= '0;
            beatCnt   <= '0;
            burstDone <= 1'b0;
        end else begin
            state     <= stateNext;
            rrPtr     <= rrPtrNext;
            grantId   <= grantIdNext;
            beatCnt   <= beatCntNext;
            burstDone <= burstDoneNext;
        end
    end

    always_comb begin
        stateNext     = state;
        rrPtrNext     = rrPtr;
        grantIdNext   = grantId;
        beatCntNext   = beatCnt;
        burstDoneNext = 1'b0;
        unique case (state)
            IDLE: begin
                if (pickFound) begin
                    stateNext   = BURST;
                    grantIdNext = pickId;
                    beatCntNext = '0;
                end
            end
            BURST: begin
                if (transfer) begin
                    beatCntNext = beatCnt + CNT_W'(1);
                end
                if (releaseGrant) begin
                    stateNext     = IDLE;
                    burstDoneNext = 1'b1;
                    rrPtrNext     = (grantId == LAST_ID) ? '0 : grantId + ID_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath is steered straight from the registered grant so the payload sees no extra stage.
    always_comb begin
        bus.grant_vld  = (state == BURST);
        bus.grant_id   = grantId;
        bus.burst_done = burstDone;
        bus.out_vld    = 1'b0;
        bus.out_data   = '0;
        bus.req_rdy    = '0;
        if (state == BURST) begin
            bus.out_vld          = curVld;
            bus.out_data         = bus.req_data[grantId];
            bus.req_rdy[grantId] = bus.out_rdy;
        end
    end

endmodule

// File: tb/tb_hier_c_rr_arbiter.sv
// Bench for hier_c_rr_arbiter: directed scenarios plus random traffic against a queue-based reference.
module tb_hier_c_rr_arbiter;
    import hierIncludeC_package::*;

    localparam int N  = 4;
    localparam int MB = 8;

    logic clk;
    logic rst_n;

    hier_c_rr_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

    hier_c_rr_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MB),
        .ID_W      (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each requester is a queue of pending beats; req_vld is simply "queue not empty".
    cSt pend[N][$];
    bit outRdy;
    int mOwner, mGid, mPtr, mBeats;
    bit mDone;
    int total, bad;

    function automatic cSt mk(input logic [15:0] v);
        cSt s;
        s.cAnother = v;
        return s;
    endfunction

    function automatic int rrPick(input int ptr);
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N].size() > 0) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_vld[i] = (pend[i].size() > 0);
            if (pend[i].size() > 0) bus.req_data[i] = pend[i][0];
            else bus.req_data[i] = mk(16'h0);
        end
        bus.out_rdy = outRdy;
    endtask

    task automatic modelReset();
        mOwner = -1;
        mGid   = 0;
        mPtr   = 0;
        mBeats = 0;
        mDone  = 1'b0;
    endtask

    // Reference: owner index, beats given, pointer = one past last owner; then clock edge.
    task automatic advance();
        bit xfer;
        int own;
        xfer = 1'b0;
        if (mOwner < 0) begin
            mDone = 1'b0;
            own = rrPick(mPtr);
            if (own >= 0) begin
                mOwner = own;
                mGid   = own;
                mBeats = 0;
            end
        end else begin
            own = mOwner;
            if (pend[own].size() > 0 && outRdy) begin
                xfer = 1'b1;
                mBeats++;
            end
            if (pend[own].size() == 0 || (xfer && mBeats == MB)) begin
                mPtr   = (own + 1) % N;
                mOwner = -1;
                mDone  = 1'b1;
            end else begin
                mDone = 1'b0;
            end
            if (xfer) void'(pend[own].pop_front());
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic cleanSlate();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) pend[i].delete();
        modelReset();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        outRdy = 1'b1;
        pend[2].push_back(mk(16'h1234));
        drive();
        #2;
        total++; if (bus.grant_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_grant_vld got=%b want=0", bus.grant_vld); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_vld got=%b want=0", bus.out_vld); end
        total++; if (bus.req_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL reset_req_rdy got=%b want=0000", bus.req_rdy); end
        total++; if (bus.burst_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_burst_done got=%b want=0", bus.burst_done); end
        total++; if (bus.grant_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_grant_id got=%0d want=0", bus.grant_id); end
        pend[2].delete();
        modelReset();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
        #2;
        total++; if (bus.grant_vld !== 1'b0) begin bad++; $display("[TB] FAIL idle_grant_vld got=%b want=0", bus.grant_vld); end
    endtask

    task automatic test_single_burst();
        int gntCycle, gId, xfers, doneCycle;
        gntCycle = -1; gId = -1; xfers = 0; doneCycle = -1;
        for (int j = 0; j < 3; j++) pend[2].push_back(mk(16'(16'h0200 + j)));
        outRdy = 1'b1;
        drive();
        #2;
        for (int c = 0; c < 10; c++) begin
            if (bus.grant_vld === 1'b1 && gntCycle < 0) begin gntCycle = c; gId = int'(bus.grant_id); end
            if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) xfers++;
            if (bus.burst_done === 1'b1 && doneCycle < 0) doneCycle = c;
            advance();
            #2;
        end
        total++; if (gntCycle != 1) begin bad++; $display("[TB] FAIL single_grant_latency got=%0d want=1", gntCycle); end
        total++; if (gId != 2) begin bad++; $display("[TB] FAIL single_grant_id got=%0d want=2", gId); end
        total++; if (xfers != 3) begin bad++; $display("[TB] FAIL single_transfers got=%0d want=3", xfers); end
        total++; if (doneCycle != 5) begin bad++; $display("[TB] FAIL single_burst_done_cycle got=%0d want=5", doneCycle); end
    endtask

    // Pointer now sits at 3, so requesters 0 and 1 must be served 0 then 1.
    task automatic test_wrap();
        int gIds[$];
        bit prevGv;
        prevGv = 1'b0;
        for (int j = 0; j < 2; j++) begin
            pend[0].push_back(mk(16'(16'h0A00 + j)));
            pend[1].push_back(mk(16'(16'h0B00 + j)));
        end
        drive();
        #2;
        for (int c = 0; c < 20; c++) begin
            if (bus.grant_vld === 1'b1 && !prevGv) gIds.push_back(int'(bus.grant_id));
            prevGv = (bus.grant_vld === 1'b1);
            advance();
            #2;
        end
        total++; if (gIds.size() < 2 || gIds[0] != 0) begin bad++; $display("[TB] FAIL wrap_first_grant got=%0d want=0", gIds.size() > 0 ? gIds[0] : -1); end
        total++; if (gIds.size() < 2 || gIds[1] != 1) begin bad++; $display("[TB] FAIL wrap_second_grant got=%0d want=1", gIds.size() > 1 ? gIds[1] : -1); end
    endtask

    task automatic test_back_to_back();
        int gIds[$];
        int xc[$];
        int gaps[$];
        int gap;
        bit prevGv;
        gap = 0; prevGv = 1'b0;
        cleanSlate();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 20; j++) pend[i].push_back(mk(16'(i * 256 + j)));
        outRdy = 1'b1;
        drive();
        #2;
        for (int c = 0; c < 46; c++) begin
            if (bus.grant_vld === 1'b1) begin
                if (!prevGv) begin
                    gIds.push_back(int'(bus.grant_id));
                    xc.push_back(0);
                    gaps.push_back(gap);
                    gap = 0;
                end
                if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) xc[xc.size() - 1] = xc[xc.size() - 1] + 1;
            end else begin
                gap++;
            end
            prevGv = (bus.grant_vld === 1'b1);
            advance();
            #2;
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= gIds.size() || gIds[k] != k % N) begin
                bad++; $display("[TB] FAIL b2b_grant_order idx=%0d got=%0d want=%0d", k, k < gIds.size() ? gIds[k] : -1, k % N);
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= xc.size() || xc[k] != MB) begin
                bad++; $display("[TB] FAIL b2b_beats idx=%0d got=%0d want=%0d", k, k < xc.size() ? xc[k] : -1, MB);
            end
        end
        for (int k = 1; k < 5; k++) begin
            total++;
            if (k >= gaps.size() || gaps[k] != 1) begin
                bad++; $display("[TB] FAIL b2b_bubble idx=%0d got=%0d want=1", k, k < gaps.size() ? gaps[k] : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        int gIds[$];
        int xfers;
        bit prevGv;
        xfers = 0; prevGv = 1'b0;
        cleanSlate();
        for (int j = 0; j < 12; j++) pend[1].push_back(mk(16'(16'h1100 + j)));
        for (int j = 0; j < 3; j++) pend[3].push_back(mk(16'(16'h3300 + j)));
        outRdy = 1'b1;
        drive();
        #2;
        for (int c = 0; c < 40; c++) begin
            if (bus.grant_vld === 1'b1 && !prevGv) gIds.push_back(int'(bus.grant_id));
            prevGv = (bus.grant_vld === 1'b1);
            if (bus.grant_vld === 1'b1 && gIds.size() == 1) begin
                total++; if (bus.out_vld !== 1'b1) begin bad++; $display("[TB] FAIL bp_out_vld cyc=%0d got=%b want=1", c, bus.out_vld); end
                total++; if (bus.req_rdy !== (outRdy ? 4'b0010 : 4'b0000)) begin
                    bad++; $display("[TB] FAIL bp_req_rdy cyc=%0d got=%b want=%b", c, bus.req_rdy, outRdy ? 4'b0010 : 4'b0000);
                end
                if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) xfers++;
            end
            advance();
            outRdy = ~outRdy;
            drive();
            #2;
        end
        total++; if (gIds.size() < 1 || gIds[0] != 1) begin bad++; $display("[TB] FAIL bp_first_grant got=%0d want=1", gIds.size() > 0 ? gIds[0] : -1); end
        total++; if (xfers != MB) begin bad++; $display("[TB] FAIL bp_transfers got=%0d want=%0d", xfers, MB); end
        total++; if (gIds.size() < 2 || gIds[1] != 3) begin bad++; $display("[TB] FAIL bp_next_grant got=%0d want=3", gIds.size() > 1 ? gIds[1] : -1); end
    endtask

    task automatic test_reset_mid_burst();
        int xfers, gid;
        xfers = 0; gid = -1;
        cleanSlate();
        for (int j = 0; j < 20; j++) begin
            pend[0].push_back(mk(16'(j)));
            pend[2].push_back(mk(16'(j + 100)));
        end
        outRdy = 1'b1;
        drive();
        #2;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) xfers++;
            if (xfers == 5) break;
            advance();
            #2;
        end
        total++; if (xfers != 5) begin bad++; $display("[TB] FAIL mid_reach_beat5 got=%0d want=5", xfers); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("[TB] FAIL mid_async_out_vld got=%b want=0", bus.out_vld); end
        total++; if (bus.req_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL mid_async_req_rdy got=%b want=0000", bus.req_rdy); end
        total++; if (bus.grant_vld !== 1'b0) begin bad++; $display("[TB] FAIL mid_async_grant_vld got=%b want=0", bus.grant_vld); end
        for (int i = 0; i < N; i++) pend[i].delete();
        for (int j = 0; j < 2; j++) begin
            pend[1].push_back(mk(16'(16'h0100 + j)));
            pend[3].push_back(mk(16'(16'h0300 + j)));
        end
        modelReset();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
        #2;
        for (int c = 0; c < 5; c++) begin
            if (bus.grant_vld === 1'b1) begin gid = int'(bus.grant_id); break; end
            advance();
            #2;
        end
        total++; if (gid != 1) begin bad++; $display("[TB] FAIL mid_first_grant_after_reset got=%0d want=1", gid); end
    endtask

    task automatic test_payload();
        logic [15:0] vals[4];
        int idx;
        vals[0] = 16'h0000; vals[1] = 16'hFFFF; vals[2] = 16'hAAAA; vals[3] = 16'h5555;
        idx = 0;
        cleanSlate();
        for (int j = 0; j < 4; j++) pend[3].push_back(mk(vals[j]));
        outRdy = 1'b1;
        drive();
        #2;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1 && idx < 4) begin
                total++; if (bus.out_data.cAnother !== vals[idx]) begin
                    bad++; $display("[TB] FAIL payload beat=%0d got=%h want=%h", idx, bus.out_data.cAnother, vals[idx]);
                end
                total++; if (bus.grant_id !== 2'd3) begin bad++; $display("[TB] FAIL payload_grant beat=%0d got=%0d want=3", idx, bus.grant_id); end
                idx++;
            end
            advance();
            #2;
        end
        total++; if (idx != 4) begin bad++; $display("[TB] FAIL payload_count got=%0d want=4", idx); end
    endtask

    task automatic test_random();
        bit expGv, expOv;
        logic [N-1:0] expRdy;
        int len;
        cleanSlate();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = int'($urandom_range(1, 12));
                    for (int j = 0; j < len; j++) pend[i].push_back(mk(16'($urandom)));
                end
            end
            outRdy = ($urandom_range(0, 3) != 0);
            drive();
            #2;
            expGv  = (mOwner >= 0);
            expOv  = 1'b0;
            expRdy = '0;
            if (mOwner >= 0) begin
                expOv = (pend[mOwner].size() > 0);
                expRdy[mOwner] = outRdy;
            end
            total++; if (bus.grant_vld !== expGv) begin bad++; $display("[TB] FAIL rnd_grant_vld cyc=%0d got=%b want=%b", c, bus.grant_vld, expGv); end
            total++; if (bus.grant_id !== 2'(mGid)) begin bad++; $display("[TB] FAIL rnd_grant_id cyc=%0d got=%0d want=%0d", c, bus.grant_id, mGid); end
            total++; if (bus.out_vld !== expOv) begin bad++; $display("[TB] FAIL rnd_out_vld cyc=%0d got=%b want=%b", c, bus.out_vld, expOv); end
            total++; if (bus.req_rdy !== expRdy) begin bad++; $display("[TB] FAIL rnd_req_rdy cyc=%0d got=%b want=%b", c, bus.req_rdy, expRdy); end
            total++; if (bus.burst_done !== mDone) begin bad++; $display("[TB] FAIL rnd_burst_done cyc=%0d got=%b want=%b", c, bus.burst_done, mDone); end
            if (expOv) begin
                total++; if (bus.out_data !== pend[mOwner][0]) begin
                    bad++; $display("[TB] FAIL rnd_out_data cyc=%0d got=%h want=%h", c, bus.out_data, pend[mOwner][0]);
                end
            end
            advance();
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        outRdy = 1'b0;
        modelReset();
        drive();
        test_reset();
        test_single_burst();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_burst();
        test_payload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
